// File: rtl/mips_mem_pkg.sv
// Shared constants and the responder state type for the word memory responder.
package mips_mem_pkg;

  localparam int WORD_W      = 32;
  localparam int DEPTH_DEF   = 1024;
  localparam int LATENCY_DEF = 2;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mips_word_ram.sv
// Single-port DEPTH x 32 word storage: synchronous write, combinational read.
// Contents are deliberately not reset.
module mips_word_ram
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mips_mem_responder.sv
// Word-addressed memory responder: accepts one request, waits LATENCY cycles,
// then holds the response until the initiator takes it.
//
// state | meaning
// IDLE  | ready for a request (req_ready = 1)
// WAIT  | request latched, counter running down to the access edge
// RESP  | access done, response held until rsp_ready
module mips_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t             state_q, state_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic               lat_we;
  logic [WORD_W-1:0]  lat_addr, lat_wdata;
  logic               accept, enter_resp;
  logic               acc_we, acc_err;
  logic [WORD_W-1:0]  acc_addr, acc_wdata, ram_rdata;
  logic               ram_we;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  // rst_n gating keeps a request held across reset from reaching memory
  assign accept    = req_valid && req_ready && rst_n;

  always_comb begin
    state_nxt  = state_q;
    cnt_nxt    = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_W'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (accept) begin
      lat_we    <= req_we;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
    end
  end

  // With LATENCY=1 the access happens on the acceptance edge, so use live inputs
  assign acc_we    = req_ready ? req_we    : lat_we;
  assign acc_addr  = req_ready ? req_addr  : lat_addr;
  assign acc_wdata = req_ready ? req_wdata : lat_wdata;
  assign acc_err   = (acc_addr >= WORD_W'(DEPTH));
  assign ram_we    = enter_resp && acc_we && !acc_err;

  mips_word_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (acc_addr[AW-1:0]),
    .wdata (acc_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (enter_resp) begin
      rsp_err   <= acc_err;
      rsp_rdata <= (acc_we || acc_err) ? '0 : ram_rdata;
    end else if (state_q == RESP && rsp_ready) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end
  end

endmodule

// File: doc/mips_mem_responder.md
MIPS_MEM_RESPONDER -- requirements
Module: mips_mem_responder

Interface
REQ-001 The module SHALL have parameter DEPTH, default 1024, meaning the number of 32-bit words stored.
REQ-002 The module SHALL have parameter LATENCY, default 2, legal range 1..15, meaning the number of cycles from request acceptance to rsp_valid.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have port req_valid, input, 1 bit: the initiator presents a request.
REQ-006 The module SHALL have port req_ready, output, 1 bit: the responder can accept a request.
REQ-007 The module SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 The module SHALL have port req_addr, input, 32 bits: word address, one word per address increment.
REQ-009 The module SHALL have port req_wdata, input, 32 bits: store data.
REQ-010 The module SHALL have port rsp_valid, output, 1 bit: a response is present.
REQ-011 The module SHALL have port rsp_ready, input, 1 bit: the initiator accepts the response.
REQ-012 The module SHALL have port rsp_rdata, output, 32 bits: load data; 0 for stores and errors.
REQ-013 The module SHALL have port rsp_err, output, 1 bit: req_addr >= DEPTH.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-015 req_ready SHALL be 1 only in IDLE; a request is accepted on an edge where req_valid && req_ready.
REQ-016 On acceptance, the block SHALL latch req_we, req_addr and req_wdata, and ignore later changes on the request inputs until the next acceptance.
REQ-017 On acceptance with LATENCY=1, the FSM SHALL go to RESP; otherwise it SHALL go to WAIT with the counter loaded with LATENCY-2.
REQ-018 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL go to RESP on the edge where the counter equals 0.
REQ-019 The memory access SHALL be performed on the edge that enters RESP, so rsp_valid rises exactly LATENCY cycles after the acceptance edge.
REQ-020 A load SHALL drive rsp_rdata = mem[addr]; a store SHALL write mem[addr] = wdata and drive rsp_rdata = 0.
REQ-021 If the address is >= DEPTH (full 32-bit compare), the block SHALL set rsp_err = 1, drive rsp_rdata = 0 and suppress any write.
REQ-022 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_ready = 1; on that edge the FSM SHALL return to IDLE and rsp_valid SHALL fall.
REQ-023 A request SHALL NOT be accepted on the same edge a response completes; the minimum request spacing is LATENCY+1 cycles.
REQ-024 A load to the address of the immediately preceding store SHALL return the stored data.
REQ-025 Address DEPTH-1 SHALL be valid and address DEPTH SHALL be an error; addresses SHALL NOT wrap.

Reset
REQ-026 While rst_n = 0, the FSM SHALL be in IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, and the counter = 0.
REQ-027 Reset asserted in WAIT SHALL discard the pending request; a pending store SHALL NOT write memory.
REQ-028 Reset asserted in RESP SHALL drop the response; a store already committed SHALL remain committed.
REQ-029 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-030 Package mips_mem_pkg SHALL hold the FSM state enum, WORD_W = 32, and the default DEPTH and LATENCY constants.
REQ-031 The storage array SHALL be the sub-module mips_word_ram (single-port, synchronous write, DEPTH x 32).
REQ-032 The FSM, counter and range check SHALL reside in mips_mem_responder.

Verification
REQ-033 Scenario 1: store 0xDEADBEEF to address 5, then load address 5 -> each rsp_valid arrives 2 cycles after acceptance, rsp_err = 0, and the load returns 0xDEADBEEF.
REQ-034 Scenario 2: load address 1024 -> rsp_err = 1 and rsp_rdata = 0; a store to address 1024 leaves address 0 unchanged.
REQ-035 Scenario 3: hold rsp_ready = 0 for 5 cycles -> rsp_valid and rsp_rdata stay stable and req_ready = 0 throughout.
REQ-036 Scenario 4: assert rst_n = 0 in WAIT of a store of 0x12345678 to address 7 -> after reset, a load of address 7 returns its old value.
REQ-037 Scenario 5: with LATENCY = 1, load address 1023 -> rsp_valid on the next edge; back-to-back requests are spaced 2 cycles apart.
REQ-038 Scenario 6: change req_addr during WAIT -> the response reflects the latched address only.
